// File: rtl/fb_rect_writer.sv
// fb_rect_writer: rectangle-fill write engine for the 400x240 RGB565 frame
// buffer. Takes clipped rectangle-fill commands over a valid/ready handshake
// and emits one pixel write per cycle on the buffer RAM write port.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake
//   cmd_x/y/w/h         rectangle origin and size in pixels
//   cmd_color           RGB888 colour {R,G,B}
//   abort               cancel the fill in progress (no done pulse)
//   mem_address/write   pixel write address (y*FB_W+x) and strobe
//   mem_writedata       RGB565 pixel, mem_byteenable tied to 2'b11
//   mem_wait            RAM stall, holds the presented write
//   busy, done          engine not idle / one-cycle completion pulse
module fb_rect_writer #(
  parameter int unsigned FB_W = 400,
  parameter int unsigned FB_H = 240,
  parameter int unsigned AW   = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [8:0]    cmd_x,
  input  logic [7:0]    cmd_y,
  input  logic [8:0]    cmd_w,
  input  logic [7:0]    cmd_h,
  input  logic [23:0]   cmd_color,
  input  logic          abort,
  output logic [AW-1:0] mem_address,
  output logic          mem_write,
  output logic [15:0]   mem_writedata,
  output logic [1:0]    mem_byteenable,
  input  logic          mem_wait,
  output logic          busy,
  output logic          done
);

  localparam int unsigned XW = 9;
  localparam int unsigned YW = 8;
  localparam int unsigned PW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [XW-1:0]   w_q, w_d;
  logic [YW-1:0]   h_q, h_d;
  logic [XW-1:0]   cw_q, cw_d;
  logic [YW-1:0]   ch_q, ch_d;
  logic [XW-1:0]   col_q, col_d;
  logic [YW-1:0]   row_q, row_d;
  logic [AW-1:0]   row_base_q, row_base_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wr_q, wr_d;
  logic [PW-1:0]   data_q, data_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;

  // Setup-stage clipping terms; room values are only meaningful when the
  // origin lies on screen, which empty_c guards.
  logic [XW:0]     x_room_c;
  logic [YW:0]     y_room_c;
  logic [XW-1:0]   clip_w_c;
  logic [YW-1:0]   clip_h_c;
  logic            empty_c;
  logic [AW-1:0]   row_base_c;
  logic [AW-1:0]   next_row_c;
  logic            last_col_c;
  logic            last_row_c;
  logic [PW-1:0]   pack_c;
  logic            unused_color_c;

  assign mem_byteenable = 2'b11;
  assign cmd_ready      = ready_q;
  assign mem_address    = addr_q;
  assign mem_write      = wr_q;
  assign mem_writedata  = data_q;
  assign busy           = busy_q;
  assign done           = done_q;

  // RGB888 -> RGB565 keeps the top bits of each channel.
  assign pack_c         = {cmd_color[23:19], cmd_color[15:10], cmd_color[7:3]};
  assign unused_color_c = ^{cmd_color[18:16], cmd_color[9:8], cmd_color[2:0]};

  // Rectangle clip and start address, used only in SETUP.
  always_comb begin
    x_room_c   = (XW+1)'(FB_W) - {1'b0, x_q};
    y_room_c   = (YW+1)'(FB_H) - {1'b0, y_q};
    clip_w_c   = ({1'b0, w_q} < x_room_c) ? w_q : XW'(x_room_c);
    clip_h_c   = ({1'b0, h_q} < y_room_c) ? h_q : YW'(y_room_c);
    empty_c    = ({1'b0, x_q} >= (XW+1)'(FB_W)) || ({1'b0, y_q} >= (YW+1)'(FB_H)) ||
                 (w_q == '0) || (h_q == '0);
    row_base_c = AW'(32'(y_q) * FB_W) + AW'(x_q);
  end

  // Fill-stage row stepping is incremental; no multiplier on this path.
  assign next_row_c = row_base_q + AW'(FB_W);
  assign last_col_c = (col_q == (cw_q - XW'(1)));
  assign last_row_c = (row_q == (ch_q - YW'(1)));

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    cw_d       = cw_q;
    ch_d       = ch_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    data_d     = data_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          x_d     = cmd_x;
          y_d     = cmd_y;
          w_d     = cmd_w;
          h_d     = cmd_h;
          data_d  = pack_c;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (empty_c) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cw_d       = clip_w_c;
          ch_d       = clip_h_c;
          col_d      = '0;
          row_d      = '0;
          row_base_d = row_base_c;
          addr_d     = row_base_c;
          wr_d       = 1'b1;
          state_d    = ST_FILL;
        end
      end

      ST_FILL: begin
        if (abort) begin
          // Abort wins even over the final pixel: no done pulse.
          wr_d    = 1'b0;
          state_d = ST_IDLE;
        end else if (!mem_wait) begin
          if (last_col_c) begin
            if (last_row_c) begin
              wr_d    = 1'b0;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              col_d      = '0;
              row_d      = row_q + YW'(1);
              row_base_d = next_row_c;
              addr_d     = next_row_c;
            end
          end else begin
            col_d  = col_q + XW'(1);
            addr_d = addr_q + AW'(1);
          end
        end
      end

      default: begin
        wr_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      cw_q       <= '0;
      ch_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      cw_q       <= cw_d;
      ch_q       <= ch_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Self-checking bench for fb_rect_writer: expected pixel writes and done
// cycles are queued when a command is accepted and compared as the DUT
// produces them.
module tb_fb_rect_writer;

  localparam int unsigned FB_W = 400;
  localparam int unsigned FB_H = 240;
  localparam int unsigned AW   = 17;
  localparam int unsigned TMO  = 20000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [8:0]    cmd_x = '0;
  logic [7:0]    cmd_y = '0;
  logic [8:0]    cmd_w = '0;
  logic [7:0]    cmd_h = '0;
  logic [23:0]   cmd_color = '0;
  logic          abort = 1'b0;
  logic [AW-1:0] mem_address;
  logic          mem_write;
  logic [15:0]   mem_writedata;
  logic [1:0]    mem_byteenable;
  logic          mem_wait = 1'b0;
  logic          busy;
  logic          done;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  logic [AW+15:0] exp_wr_q[$];
  int unsigned    exp_done_q[$];

  fb_rect_writer #(.FB_W(FB_W), .FB_H(FB_H), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .abort(abort),
    .mem_address(mem_address), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_wait(mem_wait), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, got, got, exp, exp, cyc);
    end
  endtask

  function automatic logic [15:0] rgb565(input logic [23:0] c);
    return {c[23:19], c[15:10], c[7:3]};
  endfunction

  // Scoreboard monitor: every taken write and every done pulse is matched.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_write && !mem_wait) begin
        logic [AW+15:0] e;
        e = (exp_wr_q.size() != 0) ? exp_wr_q.pop_front() : '1;
        chk("wr_addr", 64'(mem_address), 64'(e[AW+15:16]));
        chk("wr_data", 64'(mem_writedata), 64'(e[15:0]));
        chk("byteen", 64'(mem_byteenable), 64'd3);
      end
      if (done) begin
        int unsigned ed;
        ed = (exp_done_q.size() != 0) ? exp_done_q.pop_front() : 32'hFFFF_FFFF;
        chk("done_cycle", 64'(cyc), 64'(ed));
      end
    end
  end

  // Golden model: clip and enumerate row-major pixel writes.
  task automatic expect_cmd(input int x, input int y, input int w, input int h,
                            input logic [23:0] c, input int unsigned t,
                            input int stall, input int max_n, input bit with_done);
    int cw, ch, n;
    cw = (x >= int'(FB_W)) ? 0 : ((w < int'(FB_W) - x) ? w : int'(FB_W) - x);
    ch = (y >= int'(FB_H)) ? 0 : ((h < int'(FB_H) - y) ? h : int'(FB_H) - y);
    n = 0;
    for (int r = 0; r < ch; r++) begin
      for (int k = 0; k < cw; k++) begin
        if (n < max_n) exp_wr_q.push_back({AW'((y + r) * int'(FB_W) + x + k), rgb565(c)});
        n++;
      end
    end
    if (with_done) exp_done_q.push_back(t + 2 + int'(cw * ch) + stall);
  endtask

  task automatic present(input int x, input int y, input int w, input int h, input logic [23:0] c);
    cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h);
    cmd_color = c;
    cmd_valid = 1'b1;
  endtask

  // Returns the acceptance cycle; resumes just after the accepting edge.
  task automatic wait_accept(output int unsigned t);
    int unsigned k;
    bit got;
    k = 0; got = 0; t = 0;
    while (!got && k < TMO) begin
      @(negedge clk);
      if (cmd_ready && cmd_valid) begin t = cyc; got = 1; end
      k++;
    end
    if (!got) chk("accept", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic go_to(input int unsigned n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    int unsigned k;
    k = 0;
    do begin @(negedge clk); k++; end
    while ((busy || exp_wr_q.size() != 0 || exp_done_q.size() != 0) && k < TMO);
    if (k >= TMO) chk("idle", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned t, t2;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk("rst_write", 64'(mem_write), 64'd0);
    chk("rst_addr", 64'(mem_address), 64'd0);
    chk("rst_data", 64'(mem_writedata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_byteen", 64'(mem_byteenable), 64'd3);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_pre_clk", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("ready_post_clk", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;

    // Full-width block clipped at the bottom edge, reaching the max address
    present(0, 200, 400, 240, 24'hFF8040);
    wait_accept(t);
    cmd_valid = 1'b0;
    expect_cmd(0, 200, 400, 240, 24'hFF8040, t, 0, 1 << 30, 1);
    @(negedge clk);
    chk("setup_no_write", 64'(mem_write), 64'd0);
    chk("setup_busy", 64'(busy), 64'd1);
    chk("setup_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("first_write", 64'(mem_write), 64'd1);
    chk("pack_fc08", 64'(mem_writedata), 64'hFC08);
    wait_idle();

    // Clipped corner
    present(398, 238, 5, 5, 24'h123456);
    wait_accept(t);
    cmd_valid = 1'b0;
    expect_cmd(398, 238, 5, 5, 24'h123456, t, 0, 1 << 30, 1);
    wait_idle();

    // Degenerate: zero width, then origin off screen
    present(10, 10, 0, 5, 24'hABCDEF);
    wait_accept(t);
    cmd_valid = 1'b0;
    expect_cmd(10, 10, 0, 5, 24'hABCDEF, t, 0, 1 << 30, 1);
    go_to(t + 3);
    @(negedge clk);
    chk("degen_w_ready", 64'(cmd_ready), 64'd1);
    wait_idle();
    present(400, 10, 5, 5, 24'h00FF00);
    wait_accept(t);
    cmd_valid = 1'b0;
    expect_cmd(400, 10, 5, 5, 24'h00FF00, t, 0, 1 << 30, 1);
    go_to(t + 3);
    @(negedge clk);
    chk("degen_x_ready", 64'(cmd_ready), 64'd1);
    wait_idle();

    // Stall on the second pixel for four cycles
    present(10, 0, 3, 1, 24'h0000FF);
    wait_accept(t);
    cmd_valid = 1'b0;
    expect_cmd(10, 0, 3, 1, 24'h0000FF, t, 4, 1 << 30, 1);
    go_to(t + 3);
    mem_wait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_addr", 64'(mem_address), 64'd11);
      chk("stall_write", 64'(mem_write), 64'd1);
      @(posedge clk); #1;
    end
    mem_wait = 1'b0;
    @(negedge clk);
    chk("stall_release_addr", 64'(mem_address), 64'd11);
    wait_idle();

    // Abort on the seventh write of a 20x20 fill
    present(50, 50, 20, 20, 24'h808080);
    wait_accept(t);
    cmd_valid = 1'b0;
    expect_cmd(50, 50, 20, 20, 24'h808080, t, 0, 7, 0);
    go_to(t + 8);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_write", 64'(mem_write), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    wait_idle();

    // Abort coinciding with the final write suppresses done
    present(0, 5, 2, 1, 24'hFFFFFF);
    wait_accept(t);
    cmd_valid = 1'b0;
    expect_cmd(0, 5, 2, 1, 24'hFFFFFF, t, 0, 1 << 30, 0);
    go_to(t + 3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_last_done", 64'(done), 64'd0);
    chk("abort_last_busy", 64'(busy), 64'd0);
    wait_idle();

    // Reset mid-fill, then a normal command
    present(0, 100, 20, 20, 24'h4080C0);
    wait_accept(t);
    cmd_valid = 1'b0;
    expect_cmd(0, 100, 20, 20, 24'h4080C0, t, 0, 4, 0);
    go_to(t + 6);
    rst = 1'b1;
    #1;
    chk("rst_mid_write", 64'(mem_write), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_addr", 64'(mem_address), 64'd0);
    chk("rst_mid_ready", 64'(cmd_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    present(100, 20, 4, 3, 24'h00FFFF);
    wait_accept(t);
    cmd_valid = 1'b0;
    expect_cmd(100, 20, 4, 3, 24'h00FFFF, t, 0, 1 << 30, 1);
    wait_idle();

    // Back-to-back with cmd_valid held high
    present(5, 5, 3, 2, 24'hF0F0F0);
    wait_accept(t);
    expect_cmd(5, 5, 3, 2, 24'hF0F0F0, t, 0, 1 << 30, 1);
    present(7, 9, 2, 2, 24'h0F0F0F);
    wait_accept(t2);
    cmd_valid = 1'b0;
    chk("b2b_accept_cycle", 64'(t2), 64'(t + 2 + 6));
    expect_cmd(7, 9, 2, 2, 24'h0F0F0F, t2, 0, 1 << 30, 1);
    wait_idle();

    chk("wr_queue_left", 64'(exp_wr_q.size()), 64'd0);
    chk("done_queue_left", 64'(exp_done_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
